// File: rtl/qpp_interleaver_pp.sv
// Ping-pong, bit-serial QPP turbo interleaver: two 1-bit banks filled sequentially,
// drained in pi(j) = (F1*j + F2*j^2) mod K order, with the addresses generated by recursion.
module qpp_interleaver_pp #(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned K_SMALL  = 1056,
    parameter int unsigned F1_SMALL = 17,
    parameter int unsigned F2_SMALL = 66,
    parameter int unsigned K_LARGE  = 6144,
    parameter int unsigned F1_LARGE = 263,
    parameter int unsigned F2_LARGE = 480
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_data,
    input  logic in_start,
    input  logic in_blocksize,
    output logic in_ready,
    output logic out_valid,
    output logic out_data,
    output logic out_start,
    output logic out_end,
    output logic out_blocksize,
    input  logic out_ready,
    output logic done
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   sum_t;

    localparam sum_t  K_S  = sum_t'(K_SMALL);
    localparam sum_t  K_L  = sum_t'(K_LARGE);
    localparam addr_t G0_S = addr_t'((F1_SMALL + F2_SMALL) % K_SMALL);
    localparam addr_t G0_L = addr_t'((F1_LARGE + F2_LARGE) % K_LARGE);
    localparam addr_t D_S  = addr_t'((2 * F2_SMALL) % K_SMALL);
    localparam addr_t D_L  = addr_t'((2 * F2_LARGE) % K_LARGE);

    typedef enum logic {W_IDLE, W_FILL} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM} rstate_t;

    function automatic addr_t add_mod(input addr_t a, input addr_t b, input sum_t k);
        sum_t s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= k) s = s - k;
        return s[ADDR_W-1:0];
    endfunction

    logic    mem0 [0:DEPTH-1];
    logic    mem1 [0:DEPTH-1];
    logic    rdata;
    logic [1:0] full, bank_bs, set_mask, clr_mask;

    wstate_t wstate, wstate_nx;
    logic    wbank, we, w_first, w_set, accept;
    addr_t   waddr, wa;
    sum_t    k_w_last;

    rstate_t rstate, rstate_nx;
    logic    rbank, re, r_clr, rs, consume, last_beat, streaming;
    addr_t   pi, g, j, ra, pi_nx, g_nx, g0_r, d_r;
    sum_t    k_r;

    // ---------------- write side ----------------
    assign in_ready = ~full[wbank];
    assign accept   = in_valid & in_ready;
    assign k_w_last = (bank_bs[wbank] ? K_L : K_S) - 1'b1;

    always_comb begin
        wstate_nx = wstate;
        we        = 1'b0;
        wa        = '0;
        w_first   = 1'b0;
        w_set     = 1'b0;
        case (wstate)
            W_IDLE: if (accept && in_start) begin
                we        = 1'b1;
                w_first   = 1'b1;
                wstate_nx = W_FILL;
            end
            W_FILL: if (accept) begin
                we = 1'b1;
                wa = waddr;
                if ({1'b0, waddr} == k_w_last) begin
                    w_set     = 1'b1;
                    wstate_nx = W_IDLE;
                end
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate  <= W_IDLE;
            wbank   <= 1'b0;
            waddr   <= '0;
            bank_bs <= '0;
        end else begin
            wstate <= wstate_nx;
            if (w_first) begin
                bank_bs[wbank] <= in_blocksize;
                waddr          <= addr_t'(1);
            end else if (we) begin
                waddr <= waddr + 1'b1;
            end
            if (w_set) wbank <= ~wbank;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            if (wbank) mem1[wa] <= in_data;
            else       mem0[wa] <= in_data;
        end
    end

    // Set and clear always target different banks, so both apply in one cycle.
    assign set_mask = w_set ? (wbank ? 2'b10 : 2'b01) : 2'b00;
    assign clr_mask = r_clr ? (rbank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) full <= '0;
        else       full <= (full & ~clr_mask) | set_mask;
    end

    // ---------------- read side ----------------
    assign rs        = bank_bs[rbank];
    assign k_r       = rs ? K_L : K_S;
    assign g0_r      = rs ? G0_L : G0_S;
    assign d_r       = rs ? D_L : D_S;
    assign pi_nx     = add_mod(pi, g, k_r);
    assign g_nx      = add_mod(g, d_r, k_r);
    assign last_beat = ({1'b0, j} == k_r - 1'b1);
    assign streaming = (rstate == R_STREAM);
    assign consume   = streaming & out_ready;

    always_comb begin
        rstate_nx = rstate;
        re        = 1'b0;
        ra        = '0;
        r_clr     = 1'b0;
        case (rstate)
            R_IDLE:  if (full[rbank]) rstate_nx = R_PRIME;
            R_PRIME: begin
                re        = 1'b1;
                rstate_nx = R_STREAM;
            end
            R_STREAM: if (out_ready) begin
                if (last_beat) begin
                    r_clr     = 1'b1;
                    rstate_nx = full[~rbank] ? R_PRIME : R_IDLE;
                end else begin
                    re = 1'b1;
                    ra = pi_nx;
                end
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate <= R_IDLE;
            rbank  <= 1'b0;
            pi     <= '0;
            g      <= '0;
            j      <= '0;
            done   <= 1'b0;
        end else begin
            rstate <= rstate_nx;
            done   <= consume & last_beat;
            if (rstate == R_PRIME) begin
                pi <= '0;
                g  <= g0_r;
                j  <= '0;
            end else if (consume && !last_beat) begin
                pi <= pi_nx;
                g  <= g_nx;
                j  <= j + 1'b1;
            end
            if (r_clr) rbank <= ~rbank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)   rdata <= 1'b0;
        else if (re) rdata <= rbank ? mem1[ra] : mem0[ra];
    end

    assign out_valid     = streaming;
    assign out_data      = streaming & rdata;
    assign out_start     = streaming & (j == '0);
    assign out_end       = streaming & last_beat;
    assign out_blocksize = streaming & rs;
endmodule

// File: tb/tb_qpp_interleaver_pp.sv
// Scoreboard bench for qpp_interleaver_pp: driver pushes model output per completed block,
// monitor pops and compares each consumed beat, and checks stall stability and done.
module tb_qpp_interleaver_pp;
    logic clk = 1'b0;
    logic reset, in_valid, in_data, in_start, in_blocksize, out_ready;
    logic in_ready, out_valid, out_data, out_start, out_end, out_blocksize, done;

    always #5 clk = ~clk;

    qpp_interleaver_pp #(
        .ADDR_W(13), .K_SMALL(1056), .F1_SMALL(17), .F2_SMALL(66),
        .K_LARGE(6144), .F1_LARGE(263), .F2_LARGE(480)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_start(in_start), .in_blocksize(in_blocksize), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_start(out_start),
        .out_end(out_end), .out_blocksize(out_blocksize), .out_ready(out_ready),
        .done(done)
    );

    typedef struct packed {logic d; logic s; logic e; logic bs;} beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          ready_mode = 1;  // 0 hold low, 1 always high, 2 random 50%
    int          beat_no = 0;
    int          st_a, st_b, st_c, st_x;
    logic        blk [0:6143];
    logic [15:0] lfsr = 16'hACE1;

    function automatic int unsigned qpp(input int unsigned jj, input int unsigned k,
                                        input int unsigned f1, input int unsigned f2);
        longint unsigned x;
        x = jj;
        return int'((longint'(f1) * x + longint'(f2) * x * x) % longint'(k));
    endfunction

    function automatic logic lfsr_bit();
        logic b;
        b = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        lfsr = {b, lfsr[15:1]};
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Sends one block; returns just after a rising edge. abort_at>=0 resets mid-block.
    task automatic send_block(input logic bs, input int stray, input int midstart,
                              input int gap_pct, input int abort_at, input bit use_lfsr,
                              output int stalls);
        int unsigned k, f1, f2;
        int n;
        logic acc;
        k  = bs ? 6144 : 1056;
        f1 = bs ? 263 : 17;
        f2 = bs ? 480 : 66;
        stalls = 0;
        for (int i = 0; i < int'(k); i++) blk[i] = use_lfsr ? lfsr_bit() : 1'($urandom);
        for (int s = 0; s < stray; s++) begin
            #1 in_valid = 1'b1; in_start = 1'b0; in_data = 1'($urandom);
            in_blocksize = 1'($urandom);
            @(posedge clk);
        end
        for (int i = 0; i < int'(k); i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                #1 in_valid = 1'b0; in_start = 1'($urandom);
                @(posedge clk);
            end
            if (i == abort_at) begin
                #1 reset = 1'b1; in_valid = 1'b0; in_start = 1'b0;
                exp_q.delete();
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            #1 in_valid = 1'b1;
            in_start     = (i == 0) || (i == midstart);
            in_blocksize = (i == 0) ? bs : 1'($urandom);
            in_data      = blk[i];
            n = 0;
            forever begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                if (acc) break;
                stalls++;
                n++;
                if (n > 20000) begin
                    check("in_accept_timeout", 32'(n), 32'(0));
                    return;
                end
            end
        end
        for (int unsigned jj = 0; jj < k; jj++)
            exp_q.push_back('{blk[qpp(jj, k, f1, f2)], jj == 0, jj == k - 1, bs});
    endtask

    task automatic idle_inputs();
        #1 in_valid = 1'b0; in_start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor
    initial begin
        logic  prev_stall, pend_done;
        beat_t prev_b, got, e;
        prev_stall = 1'b0;
        pend_done  = 1'b0;
        prev_b     = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                pend_done  = 1'b0;
            end else begin
                got = {out_data, out_start, out_end, out_blocksize};
                check("done", 32'(done), 32'(pend_done));
                if (prev_stall)
                    check("stall_hold", 32'({out_valid, got}), 32'({1'b1, prev_b}));
                pend_done = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(got), 32'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (got !== e) begin
                            failures++;
                            $display("FAIL beat %0d actual{d,s,e,bs}=%b required=%b", beat_no, got, e);
                        end
                        pend_done = e.e;
                        beat_no++;
                    end
                end
                prev_stall = out_valid & ~out_ready;
                prev_b     = got;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_start = 1'b0; in_blocksize = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_state", 32'({in_ready, out_valid, out_data, out_start, out_end, out_blocksize, done}),
              32'(7'b1000000));

        // 1: small block, LFSR data, latency from last accepted bit
        ready_mode = 1;
        @(posedge clk);
        send_block(1'b0, 0, -1, 0, -1, 1'b1, st_a);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("latency_edge1", 32'(out_valid), 32'(0));
        @(negedge clk);
        check("latency_edge2", 32'(out_valid), 32'(1));
        wait_drain();

        // 2: large block
        @(posedge clk);
        send_block(1'b1, 0, -1, 0, -1, 1'b0, st_a);
        idle_inputs();
        wait_drain();

        // 3: back-to-back small, large, small with the reader held off
        ready_mode = 0;
        @(posedge clk);
        send_block(1'b0, 0, -1, 0, -1, 1'b0, st_a);
        send_block(1'b1, 0, -1, 0, -1, 1'b0, st_b);
        check("blk2_no_stall", 32'(st_b), 32'(0));
        fork
            send_block(1'b0, 0, -1, 0, -1, 1'b0, st_c);
            begin
                repeat (40) @(negedge clk);
                check("blk3_blocked", 32'(in_ready), 32'(0));
                ready_mode = 1;
            end
        join
        idle_inputs();
        check("blk3_stalled", 32'(st_c > 0), 32'(1));
        wait_drain();

        // 4: random input gaps and 50% out_ready
        ready_mode = 2;
        @(posedge clk);
        send_block(1'b0, 0, -1, 30, -1, 1'b0, st_a);
        send_block(1'b1, 0, -1, 30, -1, 1'b0, st_b);
        idle_inputs();
        wait_drain();

        // 5: buffered block plus partial block discarded by reset
        ready_mode = 0;
        @(posedge clk);
        send_block(1'b0, 0, -1, 0, -1, 1'b0, st_a);
        send_block(1'b1, 0, -1, 0, 500, 1'b0, st_x);
        @(negedge clk);
        check("post_reset_out_valid", 32'(out_valid), 32'(0));
        check("post_reset_in_ready", 32'(in_ready), 32'(1));
        ready_mode = 1;
        @(posedge clk);
        send_block(1'b0, 0, -1, 0, -1, 1'b0, st_a);
        idle_inputs();
        wait_drain();

        // 6: stray beats while idle, in_start mid-fill, then a following block
        @(posedge clk);
        send_block(1'b0, 5, 300, 0, -1, 1'b0, st_a);
        send_block(1'b0, 0, 700, 10, -1, 1'b0, st_b);
        idle_inputs();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
